top_ab_sifting: RTL and testbench

- Self-contained two-party BB84 sifting block covering the Alice and Bob sides of the QKD post-processing chain.
- On a start request it generates one frame of raw pulses internally: Alice bit/basis, Bob basis, Bob detection and channel error.
- It keeps Z-basis matches as sifted key. Each party's sifted key is packed into 64-bit words and written to its own external BRAM (port A).
- X-basis matches are accumulated into visibility statistics, which are reported once per frame together with finish pulses.

---
 rtl/ab_sifting_pkg.sv | 27 ++
 rtl/top_ab_sifting_pulse_gen.sv | 55 +++++
 rtl/top_ab_sifting.sv | 237 +++++++++++++++++++++++
 tb/tb_top_ab_sifting.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ab_sifting_pkg.sv
// Shared constants and types for the two-party BB84 sifting block.
// Holds key/address widths, the LFSR polynomial and default seed, the basis
// encoding and the frame FSM state type.
package ab_sifting_pkg;

    localparam int unsigned KEY_W  = 64;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned BCNT_W = 6;
    localparam int unsigned LFSR_W = 32;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form (taps 32,22,2,1)
    localparam logic [LFSR_W-1:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 32'hACE1_2468;

    typedef enum logic {
        BasisZ = 1'b0,
        BasisX = 1'b1
    } basis_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

endpackage

// File: rtl/top_ab_sifting_pulse_gen.sv
// sifting_pulse_gen: raw-pulse source for the sifting block.
// A 32-bit Galois LFSR whose current state is decoded into one pulse:
// Alice bit/basis, Bob basis, Bob detection and Bob bit (with optional
// channel error).
//   clk_i, rst_ni : clock, async active-low reset (loads the seed)
//   load_i        : reload the seed (frame start), takes priority
//   adv_i         : advance the LFSR one step
//   a_bit_o, a_basis_o, b_basis_o, det_o, b_bit_o : decoded pulse fields
module sifting_pulse_gen
    import ab_sifting_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT,
    parameter bit                ERR_EN    = 1'b1
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  logic   adv_i,
    output logic   a_bit_o,
    output basis_e a_basis_o,
    output basis_e b_basis_o,
    output logic   det_o,
    output logic   b_bit_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              err;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = LFSR_SEED;
        end else if (adv_i) begin
            lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_POLY : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Fields are decoded from the current state, so the first pulse of a
    // frame uses the seed itself.
    assign a_bit_o   = lfsr_q[0];
    assign a_basis_o = basis_e'(lfsr_q[1]);
    assign b_basis_o = basis_e'(lfsr_q[2]);
    assign det_o     = (lfsr_q[5:3] != 3'd0);
    assign err       = ERR_EN && (lfsr_q[11:6] == 6'd0);
    assign b_bit_o   = lfsr_q[0] ^ err;

endmodule

// File: rtl/top_ab_sifting.sv
// top_ab_sifting: two-party BB84 sifting for one internally generated frame.
// On a start_switch rising edge, NUM_PULSE pulses are generated; Z-basis
// matches are packed MSB-first into 64-bit words written to the Alice and Bob
// BRAM ports, X-basis matches feed visibility statistics, and finish pulses
// mark the end of the frame.
//   clk, rst_n, start_switch       : clock, async active-low reset, start
//   {A,B}siftedkey_{dina,addra,clka,ena,wea} : BRAM port A write interfaces
//   nvis, A_checkkey_{1,0}, A_compare_{1,0}  : X-basis statistics
//   A_visibility_valid, {A,B}_sifting_finish : end-of-frame pulses
module top_ab_sifting
    import ab_sifting_pkg::*;
#(
    parameter int unsigned       NUM_PULSE          = 65536,
    parameter logic [LFSR_W-1:0] LFSR_SEED          = LFSR_SEED_DEFAULT,
    parameter bit                ERR_EN             = 1'b1,
    parameter int unsigned       NVIS_WIDTH         = 16,
    parameter int unsigned       A_CHECKKEY_1_WIDTH = 16,
    parameter int unsigned       A_CHECKKEY_0_WIDTH = 16,
    parameter int unsigned       COMPARE_1_WIDTH    = 16,
    parameter int unsigned       COMPARE_0_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_switch,
    output logic [KEY_W-1:0]              Bsiftedkey_dina,
    output logic [ADDR_W-1:0]             Bsiftedkey_addra,
    output logic                          Bsiftedkey_clka,
    output logic                          Bsiftedkey_ena,
    output logic                          Bsiftedkey_wea,
    output logic [KEY_W-1:0]              Asiftedkey_dina,
    output logic [ADDR_W-1:0]             Asiftedkey_addra,
    output logic                          Asiftedkey_clka,
    output logic                          Asiftedkey_ena,
    output logic                          Asiftedkey_wea,
    output logic [NVIS_WIDTH-1:0]         nvis,
    output logic [A_CHECKKEY_1_WIDTH-1:0] A_checkkey_1,
    output logic [A_CHECKKEY_0_WIDTH-1:0] A_checkkey_0,
    output logic [COMPARE_1_WIDTH-1:0]    A_compare_1,
    output logic [COMPARE_0_WIDTH-1:0]    A_compare_0,
    output logic                          A_visibility_valid,
    output logic                          A_sifting_finish,
    output logic                          B_sifting_finish
);

    localparam int unsigned       PCNT_W     = $clog2(NUM_PULSE + 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(NUM_PULSE - 1);

    state_e                  state_q, state_d;
    logic                    start_q;
    logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic [KEY_W-1:0]        a_sr_q, a_sr_d, b_sr_q, b_sr_d;
    logic [ADDR_W-1:0]       widx_q, widx_d;
    logic                    wr_q, wr_d;
    logic [KEY_W-1:0]        a_word_q, a_word_d, b_word_q, b_word_d;
    logic [ADDR_W-1:0]       waddr_q, waddr_d;
    logic [NVIS_WIDTH-1:0]         nvis_q, nvis_d;
    logic [A_CHECKKEY_1_WIDTH-1:0] ck1_q, ck1_d;
    logic [A_CHECKKEY_0_WIDTH-1:0] ck0_q, ck0_d;
    logic [COMPARE_1_WIDTH-1:0]    cp1_q, cp1_d;
    logic [COMPARE_0_WIDTH-1:0]    cp0_q, cp0_d;

    logic       start_edge, gen_load, gen_adv;
    logic       a_bit, b_bit, det;
    basis_e     a_basis, b_basis;
    logic [KEY_W-1:0] a_shift, b_shift;

    sifting_pulse_gen #(
        .LFSR_SEED (LFSR_SEED),
        .ERR_EN    (ERR_EN)
    ) u_pulse_gen (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (gen_load),
        .adv_i     (gen_adv),
        .a_bit_o   (a_bit),
        .a_basis_o (a_basis),
        .b_basis_o (b_basis),
        .det_o     (det),
        .b_bit_o   (b_bit)
    );

    // start_q tracks start_switch in every state, so a level held high (or a
    // rise during a frame) never looks like a fresh edge back in StIdle.
    assign start_edge = start_switch & ~start_q;

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        bcnt_d   = bcnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        widx_d   = widx_q;
        wr_d     = 1'b0;
        a_word_d = a_word_q;
        b_word_d = b_word_q;
        waddr_d  = waddr_q;
        nvis_d   = nvis_q;
        ck1_d    = ck1_q;
        ck0_d    = ck0_q;
        cp1_d    = cp1_q;
        cp0_d    = cp0_q;
        gen_load = 1'b0;
        gen_adv  = 1'b0;
        a_shift  = {a_sr_q[KEY_W-2:0], a_bit};
        b_shift  = {b_sr_q[KEY_W-2:0], b_bit};

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d  = StRun;
                    gen_load = 1'b1;
                    pcnt_d   = '0;
                    bcnt_d   = '0;
                    a_sr_d   = '0;
                    b_sr_d   = '0;
                    widx_d   = '0;
                    nvis_d   = '0;
                    ck1_d    = '0;
                    ck0_d    = '0;
                    cp1_d    = '0;
                    cp0_d    = '0;
                end
            end
            StRun: begin
                gen_adv = 1'b1;
                pcnt_d  = pcnt_q + 1'b1;
                if (pcnt_q == PULSE_LAST) state_d = StFlush;

                if (det && a_basis == BasisZ && b_basis == BasisZ) begin
                    if (bcnt_q == '1) begin
                        wr_d     = 1'b1;
                        a_word_d = a_shift;
                        b_word_d = b_shift;
                        waddr_d  = widx_q;
                        widx_d   = widx_q + 1'b1;  // wraps 32767 -> 0
                        bcnt_d   = '0;
                        a_sr_d   = '0;
                        b_sr_d   = '0;
                    end else begin
                        a_sr_d = a_shift;
                        b_sr_d = b_shift;
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end

                if (det && a_basis == BasisX && b_basis == BasisX) begin
                    if (~&nvis_q) nvis_d = nvis_q + 1'b1;
                    if (a_bit) begin
                        if (~&ck1_q) ck1_d = ck1_q + 1'b1;
                        if (b_bit == a_bit && ~&cp1_q) cp1_d = cp1_q + 1'b1;
                    end else begin
                        if (~&ck0_q) ck0_d = ck0_q + 1'b1;
                        if (b_bit == a_bit && ~&cp0_q) cp0_d = cp0_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                state_d = StDone;
                if (bcnt_q != '0) begin
                    // Partial word: left-align so the first bit sits in bit 63.
                    wr_d     = 1'b1;
                    a_word_d = a_sr_q << (7'd64 - 7'(bcnt_q));
                    b_word_d = b_sr_q << (7'd64 - 7'(bcnt_q));
                    waddr_d  = widx_q;
                    widx_d   = widx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            pcnt_q   <= '0;
            bcnt_q   <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            widx_q   <= '0;
            wr_q     <= 1'b0;
            a_word_q <= '0;
            b_word_q <= '0;
            waddr_q  <= '0;
            nvis_q   <= '0;
            ck1_q    <= '0;
            ck0_q    <= '0;
            cp1_q    <= '0;
            cp0_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_switch;
            pcnt_q   <= pcnt_d;
            bcnt_q   <= bcnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            widx_q   <= widx_d;
            wr_q     <= wr_d;
            a_word_q <= a_word_d;
            b_word_q <= b_word_d;
            waddr_q  <= waddr_d;
            nvis_q   <= nvis_d;
            ck1_q    <= ck1_d;
            ck0_q    <= ck0_d;
            cp1_q    <= cp1_d;
            cp0_q    <= cp0_d;
        end
    end

    assign Asiftedkey_dina  = a_word_q;
    assign Asiftedkey_addra = waddr_q;
    assign Asiftedkey_clka  = clk;
    assign Asiftedkey_ena   = wr_q;
    assign Asiftedkey_wea   = wr_q;
    assign Bsiftedkey_dina  = b_word_q;
    assign Bsiftedkey_addra = waddr_q;
    assign Bsiftedkey_clka  = clk;
    assign Bsiftedkey_ena   = wr_q;
    assign Bsiftedkey_wea   = wr_q;

    assign nvis         = nvis_q;
    assign A_checkkey_1 = ck1_q;
    assign A_checkkey_0 = ck0_q;
    assign A_compare_1  = cp1_q;
    assign A_compare_0  = cp0_q;

    assign A_visibility_valid = (state_q == StDone);
    assign A_sifting_finish   = (state_q == StDone);
    assign B_sifting_finish   = (state_q == StDone);

endmodule

// File: tb/tb_top_ab_sifting.sv
// Bench for top_ab_sifting: a long frame with channel errors (dut_l) and a
// short error-free frame that ends in a partial word (dut_s), both driven by
// the same clock, reset and start. Expected words and statistics come from an
// independent software model of the pulse source.
module tb_top_ab_sifting;

    localparam int unsigned NP_L = 3000;
    localparam int unsigned NP_S = 100;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    typedef struct packed {
        logic        id;
        logic [14:0] addr;
        logic [63:0] a;
        logic [63:0] b;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_switch;

    logic [63:0] l_a_dina, l_b_dina, s_a_dina, s_b_dina;
    logic [14:0] l_a_addr, l_b_addr, s_a_addr, s_b_addr;
    logic        l_a_clka, l_b_clka, s_a_clka, s_b_clka;
    logic        l_a_ena, l_b_ena, s_a_ena, s_b_ena;
    logic        l_a_wea, l_b_wea, s_a_wea, s_b_wea;
    logic [15:0] l_nvis, l_ck1, l_ck0, l_cp1, l_cp0;
    logic [15:0] s_nvis, s_ck1, s_ck0, s_cp1, s_cp0;
    logic        l_vv, l_afin, l_bfin, s_vv, s_afin, s_bfin;
    logic        any_l, any_s;

    always #5 clk = ~clk;

    top_ab_sifting #(.NUM_PULSE(NP_L), .LFSR_SEED(SEED), .ERR_EN(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .start_switch(start_switch),
        .Bsiftedkey_dina(l_b_dina), .Bsiftedkey_addra(l_b_addr), .Bsiftedkey_clka(l_b_clka),
        .Bsiftedkey_ena(l_b_ena), .Bsiftedkey_wea(l_b_wea),
        .Asiftedkey_dina(l_a_dina), .Asiftedkey_addra(l_a_addr), .Asiftedkey_clka(l_a_clka),
        .Asiftedkey_ena(l_a_ena), .Asiftedkey_wea(l_a_wea),
        .nvis(l_nvis), .A_checkkey_1(l_ck1), .A_checkkey_0(l_ck0),
        .A_compare_1(l_cp1), .A_compare_0(l_cp0),
        .A_visibility_valid(l_vv), .A_sifting_finish(l_afin), .B_sifting_finish(l_bfin)
    );

    top_ab_sifting #(.NUM_PULSE(NP_S), .LFSR_SEED(SEED), .ERR_EN(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .start_switch(start_switch),
        .Bsiftedkey_dina(s_b_dina), .Bsiftedkey_addra(s_b_addr), .Bsiftedkey_clka(s_b_clka),
        .Bsiftedkey_ena(s_b_ena), .Bsiftedkey_wea(s_b_wea),
        .Asiftedkey_dina(s_a_dina), .Asiftedkey_addra(s_a_addr), .Asiftedkey_clka(s_a_clka),
        .Asiftedkey_ena(s_a_ena), .Asiftedkey_wea(s_a_wea),
        .nvis(s_nvis), .A_checkkey_1(s_ck1), .A_checkkey_0(s_ck0),
        .A_compare_1(s_cp1), .A_compare_0(s_cp0),
        .A_visibility_valid(s_vv), .A_sifting_finish(s_afin), .B_sifting_finish(s_bfin)
    );

    assign any_l = |{l_a_dina, l_a_addr, l_a_ena, l_a_wea, l_b_dina, l_b_addr, l_b_ena,
                     l_b_wea, l_nvis, l_ck1, l_ck0, l_cp1, l_cp0, l_vv, l_afin, l_bfin};
    assign any_s = |{s_a_dina, s_a_addr, s_a_ena, s_a_wea, s_b_dina, s_b_addr, s_b_ena,
                     s_b_wea, s_nvis, s_ck1, s_ck0, s_cp1, s_cp0, s_vv, s_afin, s_bfin};

    // ---------------- monitor (sole writer of capture state) ----------------
    wr_t caps[$];
    int  fin_cnt[2] = '{0, 0};
    time fin_t[2]   = '{0, 0};
    int  bad[2]     = '{0, 0};

    always @(negedge clk) begin
        if (l_a_ena) caps.push_back(wr_t'{id: 1'b0, addr: l_a_addr, a: l_a_dina, b: l_b_dina});
        if (s_a_ena) caps.push_back(wr_t'{id: 1'b1, addr: s_a_addr, a: s_a_dina, b: s_b_dina});
        if (l_a_ena != l_b_ena || l_a_wea != l_a_ena || l_b_wea != l_b_ena ||
            l_a_addr != l_b_addr || l_afin != l_bfin || l_afin != l_vv) bad[0]++;
        if (s_a_ena != s_b_ena || s_a_wea != s_a_ena || s_b_wea != s_b_ena ||
            s_a_addr != s_b_addr || s_afin != s_bfin || s_afin != s_vv) bad[1]++;
        if (l_afin) begin fin_cnt[0]++; fin_t[0] = $time; end
        if (s_afin) begin fin_cnt[1]++; fin_t[1] = $time; end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- software model ----------------
    logic [63:0] m_a[$], m_b[$];
    int          m_nvis, m_ck1, m_ck0, m_cp1, m_cp0, m_zerr;

    task automatic model_frame(input int unsigned num, input bit err_en);
        logic [31:0] l;
        logic [63:0] sa, sb;
        int          bc;
        bit          ab, abs, bbs, det, e, bb;
        m_a.delete(); m_b.delete();
        m_nvis = 0; m_ck1 = 0; m_ck0 = 0; m_cp1 = 0; m_cp0 = 0; m_zerr = 0;
        l = SEED; sa = '0; sb = '0; bc = 0;
        for (int unsigned i = 0; i < num; i++) begin
            ab  = l[0];
            abs = l[1];
            bbs = l[2];
            det = (l[5:3] != 3'd0);
            e   = err_en && (l[11:6] == 6'd0);
            bb  = ab ^ e;
            if (det && !abs && !bbs) begin
                sa[63-bc] = ab;
                sb[63-bc] = bb;
                m_zerr += int'(e);
                bc++;
                if (bc == 64) begin
                    m_a.push_back(sa); m_b.push_back(sb);
                    sa = '0; sb = '0; bc = 0;
                end
            end else if (det && abs && bbs) begin
                m_nvis++;
                if (ab) begin m_ck1++; if (bb == ab) m_cp1++; end
                else    begin m_ck0++; if (bb == ab) m_cp0++; end
            end
            l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        end
        if (bc != 0) begin m_a.push_back(sa); m_b.push_back(sb); end
    endtask

    task automatic check_frame(input int id, input int base, input int fin_base, input time te);
        wr_t         w;
        int          k, pc;
        int unsigned np;
        string       p;
        logic [15:0] nv, c1, c0, q1, q0;
        p  = $sformatf("d%0d", id);
        np = (id == 0) ? NP_L : NP_S;
        model_frame(np, id == 0);
        check({p, "_fin_count"}, 64'(fin_cnt[id] - fin_base), 64'd1);
        check({p, "_latency_ok"}, 64'((fin_t[id] - te - 5) / 10 <= 64'(np + 3)), 64'd1);
        check({p, "_ab_sync"}, 64'(bad[id]), 64'd0);
        k = 0; pc = 0;
        for (int i = base; i < caps.size(); i++) begin
            w = caps[i];
            if (w.id == id[0]) begin
                if (k < m_a.size()) begin
                    check($sformatf("%s_word_a[%0d]", p, k), w.a, m_a[k]);
                    check($sformatf("%s_word_b[%0d]", p, k), w.b, m_b[k]);
                    check($sformatf("%s_addr[%0d]", p, k), 64'(w.addr), 64'(k));
                end
                pc += $countones(w.a ^ w.b);
                k++;
            end
        end
        check({p, "_nwords"}, 64'(k), 64'(m_a.size()));
        check({p, "_zerr_popcount"}, 64'(pc), 64'(m_zerr));
        nv = (id == 0) ? l_nvis : s_nvis;
        c1 = (id == 0) ? l_ck1 : s_ck1;
        c0 = (id == 0) ? l_ck0 : s_ck0;
        q1 = (id == 0) ? l_cp1 : s_cp1;
        q0 = (id == 0) ? l_cp0 : s_cp0;
        check({p, "_nvis"}, 64'(nv), 64'(m_nvis));
        check({p, "_checkkey_1"}, 64'(c1), 64'(m_ck1));
        check({p, "_checkkey_0"}, 64'(c0), 64'(m_ck0));
        check({p, "_compare_1"}, 64'(q1), 64'(m_cp1));
        check({p, "_compare_0"}, 64'(q0), 64'(m_cp0));
        check({p, "_nvis_sum"}, 64'(nv), 64'(c1 + c0));
        if (id == 1) begin
            check({p, "_cmp1_eq_ck1"}, 64'(q1), 64'(c1));
            check({p, "_cmp0_eq_ck0"}, 64'(q0), 64'(c0));
        end else begin
            check({p, "_cmp1_le_ck1"}, 64'(q1 <= c1), 64'd1);
            check({p, "_cmp0_le_ck0"}, 64'(q0 <= c0), 64'd1);
        end
    endtask

    task automatic run_frame();
        int  base, fb0, fb1;
        time te;
        base = caps.size(); fb0 = fin_cnt[0]; fb1 = fin_cnt[1];
        @(negedge clk) start_switch = 1'b0;
        @(negedge clk) start_switch = 1'b1;
        te = $time + 5;
        for (int c = 0; c < int'(NP_L) + 20 && fin_cnt[0] == fb0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_frame(0, base, fb0, te);
        check_frame(1, base, fb1, te);
    endtask

    // ---------------- stimulus ----------------
    int  base, fb0, fb1;

    initial begin
        rst_n = 1'b0;
        start_switch = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_outs_l", 64'(any_l), 64'd0);
        check("rst_outs_s", 64'(any_s), 64'd0);
        check("rst_nowr", 64'(caps.size()), 64'd0);
        check("clka_eq_clk", {60'd0, l_a_clka, l_b_clka, s_a_clka, s_b_clka}, {60'd0, {4{clk}}});
        rst_n = 1'b1;

        repeat (1000) @(negedge clk);
        check("idle_nowr", 64'(caps.size()), 64'd0);
        check("idle_nofin", 64'(fin_cnt[0] + fin_cnt[1]), 64'd0);

        run_frame();

        // start held high: no retrigger
        base = caps.size(); fb0 = fin_cnt[0]; fb1 = fin_cnt[1];
        repeat (5000) @(negedge clk);
        check("hold_nowr", 64'(caps.size() - base), 64'd0);
        check("hold_nofin", 64'(fin_cnt[0] + fin_cnt[1] - fb0 - fb1), 64'd0);

        // fresh edge: identical frame thanks to seed reload
        run_frame();

        // abort mid-frame
        @(negedge clk) start_switch = 1'b0;
        @(negedge clk) start_switch = 1'b1;
        repeat (1500) @(negedge clk);
        #2;
        rst_n = 1'b0;
        start_switch = 1'b0;
        #1;
        check("abort_outs_l", 64'(any_l), 64'd0);
        check("abort_outs_s", 64'(any_s), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = caps.size(); fb0 = fin_cnt[0]; fb1 = fin_cnt[1];
        repeat (NP_L + 100) @(negedge clk);
        check("abort_nowr", 64'(caps.size() - base), 64'd0);
        check("abort_nofin", 64'(fin_cnt[0] + fin_cnt[1] - fb0 - fb1), 64'd0);

        run_frame();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
